// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, NOP/word-size constants and the
// instruction-word field positions used by both fetch and decode.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Instruction-word field positions shared with the decode control unit
    localparam int unsigned COND_MSB   = 31;
    localparam int unsigned COND_LSB   = 28;
    localparam int unsigned OP_MSB     = 27;
    localparam int unsigned OP_LSB     = 26;
    localparam int unsigned FUNCT_MSB  = 25;
    localparam int unsigned FUNCT_LSB  = 20;
    localparam int unsigned RN_MSB     = 19;
    localparam int unsigned RN_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 12;
    localparam int unsigned IMM24_MSB  = 23;
    localparam int unsigned IMM24_LSB  = 0;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: reset load, word-aligned redirect and sequential +4 advance.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              le,
    input  logic              load_target,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC[ADDR_W-1:0];
        end else if (load_target) begin
            pc <= {target[ADDR_W-1:2], 2'b00};
        end else if (le) begin
            pc <= pc + ADDR_W'(WORD_BYTES);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional perf counters (fetch_count, flush_count) under FETCH_PERF_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_le,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_link,
    output logic              ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       flush_count,
`endif
    output logic [1:0]        fetch_state
);

    fetch_state_t      state, state_next;
    logic              pc_advance, pc_redirect, ifid_load, ifid_bubble;
    logic [ADDR_W-1:0] pc;

    always_ff @(posedge clk) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    // Priority in RUN: halt, then redirect (overrides stall), then stall, then fetch
    always_comb begin
        state_next  = state;
        pc_advance  = 1'b0;
        pc_redirect = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (halt_req) begin
                    state_next  = HALT;
                    ifid_bubble = 1'b1;
                end else if (branch_taken) begin
                    pc_redirect = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (pc_le) begin
                    pc_advance = 1'b1;
                    ifid_load  = 1'b1;
                end
            end
            HALT: state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    pc_reg #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .le          (pc_advance),
        .load_target (pc_redirect),
        .target      (branch_target),
        .pc          (pc)
    );

    assign imem_addr   = pc;
    assign fetch_state = state;

    // A bubble clears instr/valid only; ifid_pc and ifid_link keep their last values
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_link  <= '0;
            ifid_valid <= 1'b0;
        end else if (ifid_load) begin
            ifid_instr <= imem_rdata;
            ifid_pc    <= pc;
            ifid_link  <= pc + ADDR_W'(WORD_BYTES);
            ifid_valid <= 1'b1;
        end else if (ifid_bubble) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (ifid_load)   fetch_count <= fetch_count + 32'd1;
            if (pc_redirect) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
